psum_acc_sfu: RTL and testbench
===============================

PSUM_ACC_SFU -- requirements
Module: psum_acc_sfu

Interface
REQ-001 SHALL have parameter col, default 4, meaning number of output lanes per vector.
REQ-002 SHALL have parameter psum_bw, default 16, meaning signed width of each psum lane.
REQ-003 SHALL have parameter addr_bw, default 4, meaning psum memory address width.
REQ-004 SHALL have ports: clk  input  1  sole clock, rising edge; reset  input  1  synchronous, active-high.
REQ-005 SHALL have ports: start  input  1  begin a pass; acc  input  1  accumulate (1) or overwrite (0); relu  input  1  apply ReLU at writeback.
REQ-006 SHALL have ports: num_vec  input  addr_bw+1  vectors in this pass; base_addr  input  addr_bw  first psum address.
REQ-007 SHALL have ports: ofifo_valid  input  1  output FIFO non-empty; ofifo_dout  input  col*psum_bw  FIFO head, lane 0 in LSBs; ofifo_rd  output  1  pop FIFO.
REQ-008 SHALL have ports: psum_rd  output  1; psum_wr  output  1; psum_addr  output  addr_bw; psum_mem_dout  input  col*psum_bw  read data; psum_mem_din  output  col*psum_bw  write data.
REQ-009 SHALL have ports: busy  output  1  pass in progress; done  output  1  one-cycle end-of-pass pulse.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, WAIT, WB, DONE.
REQ-011 SHALL, in IDLE with start=1, latch acc, relu, base_addr, num_vec; go FETCH, or DONE if num_vec=0.
REQ-012 SHALL ignore start in every state other than IDLE.
REQ-013 SHALL, in FETCH with ofifo_valid=1, assert ofifo_rd for exactly that cycle, register ofifo_dout, assert psum_rd only if latched acc=1, drive psum_addr=current address, go WAIT; with ofifo_valid=0 stay in FETCH, ofifo_rd=0.
REQ-014 SHALL treat psum_mem_dout as valid in the cycle after psum_rd (1-cycle read latency); WAIT computes per-lane result = fifo_lane + mem_lane (acc=1) or fifo_lane (acc=0), signed.
REQ-015 SHALL, with latched relu=1, replace any negative lane result by 0 after addition/saturation.
REQ-016 SHALL, in WB, assert psum_wr for one cycle with psum_mem_din=result and psum_addr=current address, then increment address (wrapping modulo 2^addr_bw) and decrement remaining count.
REQ-017 SHALL go from WB to DONE when remaining count reaches 0, else to FETCH.
REQ-018 SHALL assert done=1 for exactly the DONE cycle, then return to IDLE; busy=1 in all states except IDLE.
REQ-019 SHALL sustain one vector per 3 cycles when ofifo_valid stays high; never assert psum_rd and psum_wr in the same cycle.
REQ-020 SHALL never assert ofifo_rd when ofifo_valid=0.

Reset
REQ-021 SHALL, on reset=1 at a clock edge in any state, go IDLE, discard buffered data and count, and drive ofifo_rd, psum_rd, psum_wr, busy, done, psum_addr, psum_mem_din all to 0.
REQ-022 SHALL give reset priority over start in the same cycle.

Configuration
REQ-023 SHALL, with macro PSUM_ACC_SAT_EN defined, saturate each lane sum to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-024 SHALL, without PSUM_ACC_SAT_EN, wrap each lane sum modulo 2^psum_bw (two's complement).

Structure
REQ-025 SHALL place the FSM state enum and default col/psum_bw/addr_bw constants in shared package psum_acc_pkg.
REQ-026 SHALL implement per-lane add/saturate/ReLU in sub-module psum_acc_lane, instantiated col times; FSM and address/count logic stay in psum_acc_sfu.

Verification
REQ-027 Overwrite: acc=0, relu=0, num_vec=2, base_addr=3, FIFO {1,2,3,4},{-5,6,-7,8} -> mem[3]={1,2,3,4}, mem[4]={-5,6,-7,8}, no psum_rd, done 1 cycle.
REQ-028 Accumulate+ReLU: mem[0]={10,-20,5,0}, acc=1, relu=1, FIFO {1,2,-9,-1} -> mem[0]={11,0,0,0}.
REQ-029 Saturation: mem[1] lane0=32767, FIFO lane0=1, acc=1 -> 32767 with PSUM_ACC_SAT_EN, -32768 without.
REQ-030 Stall/wrap: base_addr=15, num_vec=2, ofifo_valid low 5 cycles between vectors -> writes to 15 then 0, ofifo_rd only when valid, pass length 6+5 cycles.
REQ-031 Reset mid-pass: reset in WAIT of vector 1 of 4 -> outputs 0 next cycle, no further psum_wr, next start begins cleanly at new base_addr.
REQ-032 num_vec=0 and start while busy -> done one cycle after start with no memory/FIFO access; mid-pass start has no effect on count or address.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// Shared constants and FSM state encoding for the psum accumulate SFU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psum_acc_pkg;

    localparam int COL_DEF     = 4;
    localparam int PSUM_BW_DEF = 16;
    localparam int ADDR_BW_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/psum_acc_lane.sv
// One psum lane: signed add (or pass-through), wrap or saturate, optional ReLU.
// Latency: combinational. Saturation is built only with PSUM_ACC_SAT_EN defined.
// Backpressure: none, pure datapath.
module psum_acc_lane
    import psum_acc_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF
) (
    input  logic [psum_bw-1:0] fifo_lane,
    input  logic [psum_bw-1:0] mem_lane,
    input  logic               acc,
    input  logic               relu,
    output logic [psum_bw-1:0] result
);

    localparam logic [psum_bw-1:0] MAX_POS = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MIN_NEG = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw-1:0] addend;
    logic [psum_bw-1:0] clip;

    // Add the memory lane only when accumulating, bound the sum, then clamp negatives if ReLU
    always_comb begin
        addend = acc ? mem_lane : '0;
`ifdef PSUM_ACC_SAT_EN
        begin : g_sat
            logic [psum_bw:0] sum;
            sum  = {fifo_lane[psum_bw-1], fifo_lane} + {addend[psum_bw-1], addend};
            // Sign bit and extension bit disagree only on overflow
            if (sum[psum_bw] != sum[psum_bw-1])
                clip = sum[psum_bw] ? MIN_NEG : MAX_POS;
            else
                clip = sum[psum_bw-1:0];
        end
`else
        clip = fifo_lane + addend;
`endif
        result = (relu && clip[psum_bw-1]) ? '0 : clip;
    end

endmodule

// File: rtl/psum_acc_sfu.sv
// Pops output-FIFO vectors, optionally accumulates with psum memory, writes back (PSUM_ACC_SAT_EN selects saturation).
// Latency: 3 cycles per vector (FETCH, WAIT, WB) plus one DONE cycle per pass; memory read latency 1.
// Backpressure: stalls in FETCH while ofifo_valid is low; start is ignored while busy.
module psum_acc_sfu
    import psum_acc_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int addr_bw = ADDR_BW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   acc,
    input  logic                   relu,
    input  logic [addr_bw:0]       num_vec,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_dout,
    output logic                   ofifo_rd,
    output logic                   psum_rd,
    output logic                   psum_wr,
    output logic [addr_bw-1:0]     psum_addr,
    input  logic [col*psum_bw-1:0] psum_mem_dout,
    output logic [col*psum_bw-1:0] psum_mem_din,
    output logic                   busy,
    output logic                   done
);

    localparam int VBW = col * psum_bw;
    localparam logic [addr_bw:0]   CNT_ZERO = '0;
    localparam logic [addr_bw:0]   CNT_ONE  = {{addr_bw{1'b0}}, 1'b1};
    localparam logic [addr_bw-1:0] ADDR_ONE = {{(addr_bw-1){1'b0}}, 1'b1};

    state_t             state;
    logic               acc_q;
    logic               relu_q;
    logic [addr_bw-1:0] addr_q;
    logic [addr_bw:0]   rem_q;
    logic [VBW-1:0]     fifo_q;
    logic [VBW-1:0]     result_q;
    logic [VBW-1:0]     lane_res;

    for (genvar g = 0; g < col; g++) begin : g_lane
        psum_acc_lane #(.psum_bw(psum_bw)) u_lane (
            .fifo_lane (fifo_q[g*psum_bw +: psum_bw]),
            .mem_lane  (psum_mem_dout[g*psum_bw +: psum_bw]),
            .acc       (acc_q),
            .relu      (relu_q),
            .result    (lane_res[g*psum_bw +: psum_bw])
        );
    end

    // Pass sequencing: latch the command, fetch, wait for memory, write back, count down
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc_q    <= 1'b0;
            relu_q   <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            fifo_q   <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_q  <= acc;
                        relu_q <= relu;
                        addr_q <= base_addr;
                        rem_q  <= num_vec;
                        state  <= (num_vec == CNT_ZERO) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (ofifo_valid) begin
                        fifo_q <= ofifo_dout;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    // Memory read data is valid this cycle
                    result_q <= lane_res;
                    state    <= WB;
                end
                WB: begin
                    addr_q <= addr_q + ADDR_ONE;
                    rem_q  <= rem_q - CNT_ONE;
                    state  <= (rem_q == CNT_ONE) ? DONE : FETCH;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from the state register; the pop is gated by valid so an empty FIFO is never read
    assign ofifo_rd     = (state == FETCH) && ofifo_valid;
    assign psum_rd      = ofifo_rd && acc_q;
    assign psum_wr      = (state == WB);
    assign psum_addr    = ((state == FETCH) || (state == WB)) ? addr_q : '0;
    assign psum_mem_din = psum_wr ? result_q : '0;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_psum_acc_sfu.sv
// Directed bench for psum_acc_sfu with a FIFO model, a 1-cycle-latency psum memory model and a protocol monitor.
// Latency: n/a.
// Backpressure: the FIFO model can be left empty to stall the DUT in FETCH.
module tb_psum_acc_sfu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        acc = 1'b0;
    logic        relu = 1'b0;
    logic [4:0]  num_vec = '0;
    logic [3:0]  base_addr = '0;
    logic        ofifo_valid;
    logic [63:0] ofifo_dout;
    logic        ofifo_rd;
    logic        psum_rd;
    logic        psum_wr;
    logic [3:0]  psum_addr;
    logic [63:0] psum_mem_dout = '0;
    logic [63:0] psum_mem_din;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    psum_acc_sfu #(.col(4), .psum_bw(16), .addr_bw(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .acc           (acc),
        .relu          (relu),
        .num_vec       (num_vec),
        .base_addr     (base_addr),
        .ofifo_valid   (ofifo_valid),
        .ofifo_dout    (ofifo_dout),
        .ofifo_rd      (ofifo_rd),
        .psum_rd       (psum_rd),
        .psum_wr       (psum_wr),
        .psum_addr     (psum_addr),
        .psum_mem_dout (psum_mem_dout),
        .psum_mem_din  (psum_mem_din),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // FIFO model
    logic [63:0] fq [0:15];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    assign ofifo_valid = (wr_ptr != rd_ptr);
    assign ofifo_dout  = fq[rd_ptr[3:0]];
    always @(posedge clk) begin
        if (reset) rd_ptr <= wr_ptr;
        else if (ofifo_rd) rd_ptr <= rd_ptr + 8'd1;
    end

    // psum memory model, 1-cycle read latency
    logic [63:0] mem [0:15];
    always @(posedge clk) begin
        if (psum_rd) psum_mem_dout <= mem[psum_addr];
        if (psum_wr) mem[psum_addr] <= psum_mem_din;
    end

    // Protocol monitor
    int rd_n = 0, wr_n = 0, pop_n = 0, viol_n = 0;
    logic [3:0] wlog [0:63];
    always @(posedge clk) begin
        if (!reset) begin
            if (psum_rd && psum_wr) viol_n <= viol_n + 1;
            if (ofifo_rd && !ofifo_valid) viol_n <= viol_n + 1;
            if (psum_rd) rd_n <= rd_n + 1;
            if (ofifo_rd) pop_n <= pop_n + 1;
            if (psum_wr) begin
                wlog[wr_n[5:0]] <= psum_addr;
                wr_n <= wr_n + 1;
            end
        end
    end

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic push(input logic [63:0] v);
        fq[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Issue one start pulse; returns at the negedge just after the accepting edge
    task automatic start_pass(input logic a, input logic r, input logic [3:0] base, input logic [4:0] n);
        @(negedge clk);
        start = 1'b1; acc = a; relu = r; base_addr = base; num_vec = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy non-done cycles until done is seen, bounded
    task automatic wait_done(output int cyc, output bit timed_out);
        cyc = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (ofifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_ofifo_rd got %b want 0", ofifo_rd); end
        n_cmp++; if (psum_rd !== 1'b0)  begin n_bad++; $display("FAIL reset_psum_rd got %b want 0", psum_rd); end
        n_cmp++; if (psum_wr !== 1'b0)  begin n_bad++; $display("FAIL reset_psum_wr got %b want 0", psum_wr); end
        n_cmp++; if (psum_addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", psum_addr); end
        n_cmp++; if (psum_mem_din !== 64'd0) begin n_bad++; $display("FAIL reset_din got %h want 0", psum_mem_din); end
        reset = 1'b0;
    endtask

    task automatic test_overwrite;
        int cyc, r0, w0; bit to;
        r0 = rd_n; w0 = wr_n;
        push(pack(1, 2, 3, 4));
        push(pack(-5, 6, -7, 8));
        start_pass(1'b0, 1'b0, 4'd3, 5'd2);
        wait_done(cyc, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL ovw_timeout got no done want done"); end
        n_cmp++; if (cyc != 6) begin n_bad++; $display("FAIL ovw_cycles got %0d want 6", cyc); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ovw_done_len got done=%b busy=%b want 0 0", done, busy); end
        n_cmp++; if (mem[3] !== pack(1, 2, 3, 4)) begin n_bad++; $display("FAIL ovw_mem3 got %h want %h", mem[3], pack(1, 2, 3, 4)); end
        n_cmp++; if (mem[4] !== pack(-5, 6, -7, 8)) begin n_bad++; $display("FAIL ovw_mem4 got %h want %h", mem[4], pack(-5, 6, -7, 8)); end
        n_cmp++; if (rd_n != r0) begin n_bad++; $display("FAIL ovw_no_psum_rd got %0d want 0", rd_n - r0); end
        n_cmp++; if (wlog[w0[5:0]] !== 4'd3 || wlog[w0[5:0]+6'd1] !== 4'd4) begin n_bad++; $display("FAIL ovw_addrs got %0d,%0d want 3,4", wlog[w0[5:0]], wlog[w0[5:0]+6'd1]); end
    endtask

    task automatic test_acc_relu;
        int cyc, r0; bit to;
        r0 = rd_n;
        mem[0] = pack(10, -20, 5, 0);
        push(pack(1, 2, -9, -1));
        start_pass(1'b1, 1'b1, 4'd0, 5'd1);
        wait_done(cyc, to);
        @(negedge clk);
        n_cmp++; if (to || cyc != 3) begin n_bad++; $display("FAIL accrelu_cycles got %0d (timeout %0d) want 3", cyc, to); end
        n_cmp++; if (mem[0] !== pack(11, 0, 0, 0)) begin n_bad++; $display("FAIL accrelu_mem0 got %h want %h", mem[0], pack(11, 0, 0, 0)); end
        n_cmp++; if (rd_n - r0 != 1) begin n_bad++; $display("FAIL accrelu_psum_rd got %0d want 1", rd_n - r0); end
    endtask

    task automatic test_saturation;
        int cyc; bit to;
        logic [63:0] exp_v;
`ifdef PSUM_ACC_SAT_EN
        exp_v = pack(32767, -32768, 50, -1);
`else
        exp_v = pack(-32768, 32767, 50, -1);
`endif
        mem[1] = pack(32767, -32768, 100, -3);
        push(pack(1, -1, -50, 2));
        start_pass(1'b1, 1'b0, 4'd1, 5'd1);
        wait_done(cyc, to);
        @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL sat_timeout got no done want done"); end
        n_cmp++; if (mem[1] !== exp_v) begin n_bad++; $display("FAIL sat_mem1 got %h want %h", mem[1], exp_v); end
    endtask

    task automatic test_stall_wrap;
        int cyc, w0, p0, v0; bit to;
        w0 = wr_n; p0 = pop_n; v0 = viol_n;
        cyc = 0; to = 1'b1;
        push(pack(7, 0, 0, 0));
        start_pass(1'b0, 1'b0, 4'd15, 5'd2);
        for (int i = 0; i < 200; i++) begin
            if (done) begin to = 1'b0; break; end
            if (busy) cyc++;
            if (i == 8) push(pack(0, 9, 0, 0));
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++; if (to || cyc != 11) begin n_bad++; $display("FAIL stall_cycles got %0d (timeout %0d) want 11", cyc, to); end
        n_cmp++; if (mem[15] !== pack(7, 0, 0, 0)) begin n_bad++; $display("FAIL stall_mem15 got %h want %h", mem[15], pack(7, 0, 0, 0)); end
        n_cmp++; if (mem[0] !== pack(0, 9, 0, 0)) begin n_bad++; $display("FAIL stall_mem0 got %h want %h", mem[0], pack(0, 9, 0, 0)); end
        n_cmp++; if (wlog[w0[5:0]] !== 4'd15 || wlog[w0[5:0]+6'd1] !== 4'd0) begin n_bad++; $display("FAIL stall_wrap got %0d,%0d want 15,0", wlog[w0[5:0]], wlog[w0[5:0]+6'd1]); end
        n_cmp++; if (pop_n - p0 != 2) begin n_bad++; $display("FAIL stall_pops got %0d want 2", pop_n - p0); end
        n_cmp++; if (viol_n != v0) begin n_bad++; $display("FAIL stall_protocol got %0d violations want 0", viol_n - v0); end
    endtask

    task automatic test_reset_midpass;
        int cyc, w0; bit to;
        w0 = wr_n;
        for (int k = 0; k < 4; k++) push(pack(k + 1, 0, 0, 0));
        start_pass(1'b0, 1'b0, 4'd5, 5'd4);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, done, ofifo_rd, psum_rd, psum_wr} !== 5'b0 || psum_addr !== 4'd0 || psum_mem_din !== 64'd0)
            begin n_bad++; $display("FAIL rstmid_outputs got busy=%b done=%b rd=%b prd=%b pwr=%b addr=%0d want all 0", busy, done, ofifo_rd, psum_rd, psum_wr, psum_addr); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (wr_n != w0) begin n_bad++; $display("FAIL rstmid_no_write got %0d writes want 0", wr_n - w0); end
        mem[9] = pack(99, 99, 99, 99);
        push(pack(4, 3, 2, 1));
        start_pass(1'b0, 1'b0, 4'd9, 5'd1);
        wait_done(cyc, to);
        @(negedge clk);
        n_cmp++; if (to || mem[9] !== pack(4, 3, 2, 1)) begin n_bad++; $display("FAIL rstmid_restart got %h want %h", mem[9], pack(4, 3, 2, 1)); end
        n_cmp++; if (wr_n - w0 != 1 || wlog[w0[5:0]] !== 4'd9) begin n_bad++; $display("FAIL rstmid_restart_addr got %0d writes addr %0d want 1 at 9", wr_n - w0, wlog[w0[5:0]]); end
    endtask

    task automatic test_zero_and_busy_start;
        int cyc, w0, r0, p0; bit to;
        w0 = wr_n; r0 = rd_n; p0 = pop_n;
        start_pass(1'b1, 1'b0, 4'd7, 5'd0);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done got %b want 1", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy); end
        n_cmp++; if (wr_n != w0 || rd_n != r0 || pop_n != p0) begin n_bad++; $display("FAIL zero_access got wr=%0d rd=%0d pop=%0d want 0 0 0", wr_n - w0, rd_n - r0, pop_n - p0); end
        push(pack(21, 0, 0, 0));
        push(pack(22, 0, 0, 0));
        start_pass(1'b0, 1'b0, 4'd2, 5'd2);
        start = 1'b1; base_addr = 4'd10; num_vec = 5'd5;
        @(negedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(cyc, to);
        cyc = cyc + 2;
        repeat (4) @(negedge clk);
        n_cmp++; if (to || cyc != 6) begin n_bad++; $display("FAIL busystart_cycles got %0d (timeout %0d) want 6", cyc, to); end
        n_cmp++; if (wr_n - w0 != 2 || wlog[w0[5:0]] !== 4'd2 || wlog[w0[5:0]+6'd1] !== 4'd3)
            begin n_bad++; $display("FAIL busystart_addrs got %0d writes at %0d,%0d want 2 at 2,3", wr_n - w0, wlog[w0[5:0]], wlog[w0[5:0]+6'd1]); end
        n_cmp++; if (mem[3] !== pack(22, 0, 0, 0)) begin n_bad++; $display("FAIL busystart_mem3 got %h want %h", mem[3], pack(22, 0, 0, 0)); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busystart_idle got %b want 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset;
        test_overwrite;
        test_acc_relu;
        test_saturation;
        test_stall_wrap;
        test_reset_midpass;
        test_zero_and_busy_start;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
